// File: rtl/data_mem_pkg.sv
// Shared types and sizing helpers for the byte-addressed data memory stage.
package data_mem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    localparam int LOW_ZERO_BYTES_DEF = 32;

    function automatic int bytes_of(input int word_len);
        return word_len / 8;
    endfunction

    function automatic int ob_of(input int word_len);
        return $clog2(word_len / 8);
    endfunction

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-wide storage with one lane-enabled write port and one registered read port.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [WORD_LEN/8-1:0]    wbe_i,
    input  logic [aw_of(DEPTH)-1:0]  waddr_i,
    input  logic [WORD_LEN-1:0]      wdata_i,
    input  logic                     re_i,
    input  logic [aw_of(DEPTH)-1:0]  raddr_i,
    output logic [WORD_LEN-1:0]      rdata_o
);
    localparam int BYTES = bytes_of(WORD_LEN);

    logic [WORD_LEN-1:0] mem_q [DEPTH];
    logic [WORD_LEN-1:0] rdata_q;

    // Storage is deliberately unreset; the controller's sweep clears it.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (we_i && wbe_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: reset-time clear sweep, request decode/error checks
// and a registered one-cycle response.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int WORD_LEN       = 32,
    parameter int DEPTH          = 256,
    parameter int LOW_ZERO_BYTES = LOW_ZERO_BYTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [WORD_LEN/8-1:0] req_be,
    input  logic [WORD_LEN-1:0]   req_addr,
    input  logic [WORD_LEN-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_LEN-1:0]   rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);
    localparam int BYTES = bytes_of(WORD_LEN);
    localparam int OB    = ob_of(WORD_LEN);
    localparam int AW    = aw_of(DEPTH);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic          ready_q;
    logic          done_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          rsp_rd_q;

    logic          accept;
    logic          misaligned;
    logic          out_of_range;
    logic          low_zero;
    logic          bad;
    logic [AW-1:0] word_idx;

    logic                arr_we;
    logic [BYTES-1:0]    arr_be;
    logic [AW-1:0]       arr_waddr;
    logic [WORD_LEN-1:0] arr_wdata;
    logic                arr_re;
    logic [WORD_LEN-1:0] arr_rdata;

    assign accept     = req_valid && ready_q;
    assign misaligned = |req_addr[OB-1:0];
    assign low_zero   = req_addr < WORD_LEN'(LOW_ZERO_BYTES);
    assign word_idx   = req_addr[OB+AW-1:OB];
    assign bad        = misaligned || out_of_range;

    // The byte space is exactly 2^(OB+AW), so any set bit above it is out of range.
    generate
        if (OB + AW < WORD_LEN) begin : g_range
            assign out_of_range = |req_addr[WORD_LEN-1:OB+AW];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate

    assign arr_re = accept && !req_we && !bad && !low_zero;

    always_comb begin
        arr_we    = 1'b0;
        arr_be    = '0;
        arr_waddr = cnt_q;
        arr_wdata = '0;
        if (state_q == INIT) begin
            arr_we = 1'b1;
            arr_be = '1;
        end else if (accept && req_we && !bad && !low_zero) begin
            arr_we    = 1'b1;
            arr_be    = req_be;
            arr_waddr = word_idx;
            arr_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && bad;
            rsp_rd_q    <= arr_re;
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    data_mem_array #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .wbe_i   (arr_be),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (word_idx),
        .rdata_o (arr_rdata)
    );

    // Writes, errors and low-zero reads never load rsp_rd_q, so they return 0.
    assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = ready_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with hand-computed expected values.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    logic        r_valid;
    logic        r_err;
    logic [31:0] r_data;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .WORD_LEN       (32),
        .DEPTH          (256),
        .LOW_ZERO_BYTES (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after a posedge; leaves the response sampled 1ns after the next one.
    task automatic xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        r_valid   = rsp_valid;
        r_err     = rsp_err;
        r_data    = rsp_rdata;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
        xfer(1'b0, 4'h0, addr, 32'h0);
        chk({tag, "_vld"}, 64'(r_valid), 64'(1'b1));
        chk({tag, "_err"}, 64'(r_err), 64'(exp_err));
        chk({tag, "_dat"}, 64'(r_data), 64'(exp_data));
    endtask

    task automatic write_chk(input string tag, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_err);
        xfer(1'b1, be, addr, wdata);
        chk({tag, "_vld"}, 64'(r_valid), 64'(1'b1));
        chk({tag, "_err"}, 64'(r_err), 64'(exp_err));
        chk({tag, "_dat"}, 64'(r_data), 64'h0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) break;
        end
        chk({tag, "_cycles"}, 64'(n), 64'd256);
        chk({tag, "_done"}, 64'(init_done), 64'(1'b1));
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_done",  64'(init_done), 64'h0);
        chk("rst_vld",   64'(rsp_valid), 64'h0);
        chk("rst_err",   64'(rsp_err),   64'h0);
        chk("rst_dat",   64'(rsp_rdata), 64'h0);

        rst = 1'b1;
        wait_ready("sweep1");

        read_chk("rd_clear", 32'h40, 32'h0, 1'b0);
        write_chk("wr_full", 4'hF, 32'h40, 32'hDEADBEEF, 1'b0);
        read_chk("rd_full", 32'h40, 32'hDEADBEEF, 1'b0);
        write_chk("wr_be9", 4'h9, 32'h40, 32'h11223344, 1'b0);
        read_chk("rd_be9", 32'h40, 32'h11ADBE44, 1'b0);
        write_chk("wr_be0", 4'h0, 32'h40, 32'hFFFFFFFF, 1'b0);
        read_chk("rd_be0", 32'h40, 32'h11ADBE44, 1'b0);

        write_chk("wr_low", 4'hF, 32'h10, 32'h12345678, 1'b0);
        read_chk("rd_low", 32'h10, 32'h0, 1'b0);
        write_chk("wr_low_edge", 4'hF, 32'h1C, 32'hCAFEF00D, 1'b0);
        read_chk("rd_low_edge", 32'h1C, 32'h0, 1'b0);
        write_chk("wr_first", 4'hF, 32'h20, 32'h01020304, 1'b0);
        read_chk("rd_first", 32'h20, 32'h01020304, 1'b0);

        read_chk("rd_misal", 32'h42, 32'h0, 1'b1);
        read_chk("rd_oor", 32'h400, 32'h0, 1'b1);
        write_chk("wr_misal", 4'hF, 32'h41, 32'hFFFFFFFF, 1'b1);
        read_chk("rd_after_misal", 32'h40, 32'h11ADBE44, 1'b0);
        write_chk("wr_oor", 4'hF, 32'h400, 32'hFFFFFFFF, 1'b1);
        read_chk("rd_word0_after_oor", 32'h0, 32'h0, 1'b0);
        write_chk("wr_last", 4'hF, 32'h3FC, 32'hA5A55A5A, 1'b0);
        read_chk("rd_last", 32'h3FC, 32'hA5A55A5A, 1'b0);
        write_chk("wr_lane2", 4'h2, 32'h3FC, 32'h0000C300, 1'b0);
        read_chk("rd_lane2", 32'h3FC, 32'hA5A5C35A, 1'b0);

        @(posedge clk);
        #1;
        chk("idle_vld", 64'(rsp_valid), 64'h0);

        // Reset during back-to-back reads: the in-flight response vanishes at once.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        @(posedge clk);
        #1;
        chk("b2b_vld", 64'(rsp_valid), 64'h1);
        chk("b2b_dat", 64'(rsp_rdata), 64'h11ADBE44);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_vld", 64'(rsp_valid), 64'h0);
        chk("rst_mid_dat", 64'(rsp_rdata), 64'h0);
        chk("rst_mid_ready", 64'(req_ready), 64'h0);
        req_valid = 1'b0;
        req_addr  = 32'h0;
        @(posedge clk);
        #1;

        // Restart the sweep, interrupt it at cycle 100, then let it finish.
        rst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("sweep_mid_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ready("sweep2");
        read_chk("rd_cleared", 32'h40, 32'h0, 1'b0);
        read_chk("rd_last_cleared", 32'h3FC, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
